seq_detect_param: RTL and testbench

Parametrised byte-stream sequence detector. It watches an 8-bit character stream and emits a one-cycle pulse each time a compile-time pattern of up to 8 characters completes. Configurable options are case-insensitive matching, overlapping or non-overlapping detection, a data-valid qualifier, and a saturating match counter. It replaces the fixed single-word ("Hello") detector state machine in character-stream designs.

---
 rtl/seq_detect_param_if.sv | 24 ++
 rtl/seq_detect_param.sv | 91 +++++++++
 tb/tb_seq_detect_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - character stream and match result bundle for seq_detect_param
interface seq_detect_param_if;
    logic [7:0]  data;
    logic        data_vld;
    logic        clr_cnt;
    logic        out;
    logic [15:0] match_cnt;

    modport master (
        output data,
        output data_vld,
        output clr_cnt,
        input  out,
        input  match_cnt
    );

    modport slave (
        input  data,
        input  data_vld,
        input  clr_cnt,
        output out,
        output match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised byte-stream pattern detector with saturating match counter
module seq_detect_param #(
    parameter int PAT_LEN     = 5,
    parameter     PATTERN     = "Hello",
    parameter int CASE_INSENS = 1,
    parameter int OVERLAP     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    seq_detect_param_if.slave bus
);

    if (PAT_LEN < 1 || PAT_LEN > 8) begin : g_bad_len
        $error("seq_detect_param: PAT_LEN must be in 1..8");
    end
    if ($bits(PATTERN) != 8 * PAT_LEN) begin : g_bad_pat
        $error("seq_detect_param: PATTERN width must equal 8*PAT_LEN");
    end

    localparam int HIST   = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
    localparam int HW     = 8 * HIST;
    localparam int FILL_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [8*PAT_LEN-1:0] PAT_V    = PATTERN;

    function automatic logic [7:0] fold(input logic [7:0] b);
        if (CASE_INSENS != 0 && b >= 8'h41 && b <= 8'h5A) begin
            return b | 8'h20;
        end
        return b;
    endfunction

    // History byte 0 (low byte) is the oldest, so it lines up with the pattern's first character.
    logic [HW-1:0]     hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              out_q;
    logic [7:0]        cur_f;
    logic              seq_eq;
    logic              match;

    always_comb begin
        cur_f  = fold(bus.data);
        seq_eq = (cur_f == fold(PAT_V[7:0]));
        for (int i = 0; i < PAT_LEN - 1; i++) begin
            if (hist_q[8*i +: 8] != fold(PAT_V[8*(PAT_LEN-i)-1 -: 8])) begin
                seq_eq = 1'b0;
            end
        end
        match = bus.data_vld && (fill_q == FILL_MAX) && seq_eq;

        fill_d = fill_q;
        hist_d = hist_q;
        if (bus.data_vld) begin
            if (match && OVERLAP == 0) begin
                fill_d = '0;
            end else begin
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
                hist_d = HW'({cur_f, hist_q} >> 8);
            end
        end

        // A clear wins over a simultaneous match; the pulse itself is unaffected.
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (match && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            out_q  <= match;
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed vector bench for seq_detect_param across several parameter sets
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_detect_param_if if0 ();
    seq_detect_param_if if1 ();
    seq_detect_param_if if2 ();
    seq_detect_param_if if3 ();
    seq_detect_param_if if4 ();

    seq_detect_param u_d0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    seq_detect_param #(.CASE_INSENS(0)) u_d1 (.clk_i(clk), .rst_i(rst), .bus(if1));
    seq_detect_param #(.PAT_LEN(2), .PATTERN("aa"), .OVERLAP(1)) u_d2 (.clk_i(clk), .rst_i(rst), .bus(if2));
    seq_detect_param #(.PAT_LEN(2), .PATTERN("aa"), .OVERLAP(0)) u_d3 (.clk_i(clk), .rst_i(rst), .bus(if3));
    seq_detect_param #(.PAT_LEN(1), .PATTERN("a")) u_d4 (.clk_i(clk), .rst_i(rst), .bus(if4));

    typedef struct {
        logic        r;
        logic [7:0]  d;
        logic        v;
        logic [3:0]  eo;
        logic        ck;
        logic [15:0] c0, c1, c2, c3;
    } vec_t;

    vec_t tab[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] outs;
    assign outs = {if3.out, if2.out, if1.out, if0.out};

    function automatic vec_t mk(logic r, logic [7:0] d, logic v, logic [3:0] eo,
                                logic ck = 1'b0, int c0 = 0, int c1 = 0, int c2 = 0, int c3 = 0);
        vec_t t;
        t.r = r; t.d = d; t.v = v; t.eo = eo; t.ck = ck;
        t.c0 = 16'(c0); t.c1 = 16'(c1); t.c2 = 16'(c2); t.c3 = 16'(c3);
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [7:0] d, input logic v, input logic c);
        rst = r;
        if0.data = d; if1.data = d; if2.data = d; if3.data = d; if4.data = d;
        if0.data_vld = v; if1.data_vld = v; if2.data_vld = v; if3.data_vld = v; if4.data_vld = v;
        if0.clr_cnt = c; if1.clr_cnt = c; if2.clr_cnt = c; if3.clr_cnt = c; if4.clr_cnt = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add_word(input string s);
        for (int i = 0; i < s.len(); i++) tab.push_back(mk(1'b0, s[i], 1'b1, 4'b0000));
    endtask

    initial begin
        string stream;
        int    bad;
        stream = "AKLHELLOHelMPHellook";

        apply(1'b0, 8'h00, 1'b0, 1'b0);

        tab.push_back(mk(1'b1, 8'h00, 1'b0, 4'b0000, 1'b1, 0, 0, 0, 0));
        for (int i = 0; i < stream.len(); i++) begin
            logic [3:0] e;
            e = (i == 7) ? 4'b0001 : (i == 17) ? 4'b0011 : 4'b0000;
            tab.push_back(mk(1'b0, stream[i], 1'b1, e, (i == 19), 2, 1, 0, 0));
        end
        add_word("Hel");
        for (int i = 0; i < 3; i++) tab.push_back(mk(1'b0, "X", 1'b0, 4'b0000));
        tab.push_back(mk(1'b0, "l", 1'b1, 4'b0000));
        tab.push_back(mk(1'b0, "o", 1'b1, 4'b0011, 1'b1, 3, 2, 0, 0));

        tab.push_back(mk(1'b1, 8'h00, 1'b0, 4'b0000, 1'b1, 0, 0, 0, 0));
        tab.push_back(mk(1'b0, "a", 1'b1, 4'b0000));
        tab.push_back(mk(1'b0, "a", 1'b1, 4'b1100));
        tab.push_back(mk(1'b0, "a", 1'b1, 4'b0100));
        tab.push_back(mk(1'b0, "a", 1'b1, 4'b1100, 1'b1, 0, 0, 3, 2));

        tab.push_back(mk(1'b1, 8'h00, 1'b0, 4'b0000));
        add_word("Hel");
        tab.push_back(mk(1'b1, 8'h00, 1'b0, 4'b0000));
        tab.push_back(mk(1'b0, "l", 1'b1, 4'b0000));
        tab.push_back(mk(1'b0, "o", 1'b1, 4'b0000, 1'b1, 0, 0, 0, 0));
        add_word("Hell");
        tab.push_back(mk(1'b0, "o", 1'b1, 4'b0011, 1'b1, 1, 1, 0, 0));

        add_word("Hell");
        tab.push_back(mk(1'b1, "o", 1'b1, 4'b0000, 1'b1, 0, 0, 0, 0));
        tab.push_back(mk(1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 0, 0, 0, 0));

        foreach (tab[n]) begin
            apply(tab[n].r, tab[n].d, tab[n].v, 1'b0);
            for (int k = 0; k < 4; k++)
                check($sformatf("row%0d_out_d%0d", n, k), 32'(outs[k]), 32'(tab[n].eo[k]));
            if (tab[n].ck) begin
                check($sformatf("row%0d_cnt_d0", n), 32'(if0.match_cnt), 32'(tab[n].c0));
                check($sformatf("row%0d_cnt_d1", n), 32'(if1.match_cnt), 32'(tab[n].c1));
                check($sformatf("row%0d_cnt_d2", n), 32'(if2.match_cnt), 32'(tab[n].c2));
                check($sformatf("row%0d_cnt_d3", n), 32'(if3.match_cnt), 32'(tab[n].c3));
            end
        end

        // Single-character pattern: saturation, clear-on-match, and a bubble.
        apply(1'b1, 8'h00, 1'b0, 1'b0);
        check("sat_reset_out", 32'(if4.out), 32'd0);
        check("sat_reset_cnt", 32'(if4.match_cnt), 32'd0);
        bad = 0;
        for (int i = 0; i < 65540; i++) begin
            apply(1'b0, "a", 1'b1, 1'b0);
            if (if4.out !== 1'b1) bad++;
        end
        check("sat_out_every_cycle_bad", 32'(bad), 32'd0);
        check("sat_cnt", 32'(if4.match_cnt), 32'hFFFF);
        apply(1'b0, "a", 1'b1, 1'b1);
        check("clr_match_out", 32'(if4.out), 32'd1);
        check("clr_match_cnt", 32'(if4.match_cnt), 32'd0);
        apply(1'b0, "a", 1'b1, 1'b0);
        check("after_clr_out", 32'(if4.out), 32'd1);
        check("after_clr_cnt", 32'(if4.match_cnt), 32'd1);
        apply(1'b0, "a", 1'b0, 1'b0);
        check("bubble_out", 32'(if4.out), 32'd0);
        check("bubble_cnt", 32'(if4.match_cnt), 32'd1);
        apply(1'b0, "b", 1'b1, 1'b0);
        check("nomatch_out", 32'(if4.out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
